// File: rtl/mio_pkg.sv
// Shared definitions for the MIO bus controller: FSM encoding and width helper.
package mio_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } state_e;

  // Ceiling log2; returns 0 for v <= 1, callers clamp to a 1-bit minimum.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mio_irq_ctrl.sv
// Interrupt front end: per-source synchroniser, rising-edge detect, pending register,
// lowest-index priority encoder and registered CPU interrupt request.
module mio_irq_ctrl
  import mio_pkg::*;
#(
  parameter int unsigned NINT = 4,
  localparam int unsigned IDW = (clog2(NINT) < 1) ? 1 : clog2(NINT)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NINT-1:0] irq_in,
  input  logic [NINT-1:0] irq_en,
  input  logic [NINT-1:0] irq_clr,
  output logic [NINT-1:0] irq_pending,
  output logic [IDW-1:0]  irq_id,
  output logic            cpu_int
);

  logic [NINT-1:0] r_sync1, r_sync2, r_prev;
  logic [NINT-1:0] w_edge, w_masked;

  assign w_edge   = r_sync2 & ~r_prev;
  assign w_masked = irq_pending & irq_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_prev      <= '0;
      irq_pending <= '0;
      cpu_int     <= 1'b0;
    end else begin
      r_sync1     <= irq_in;
      r_sync2     <= r_sync1;
      r_prev      <= r_sync2;
      // A fresh edge overrides a clear landing in the same cycle.
      irq_pending <= (irq_pending & ~irq_clr) | w_edge;
      cpu_int     <= |w_masked;
    end
  end

  always_comb begin
    irq_id = '0;
    for (int i = NINT - 1; i >= 0; i--) begin
      if (w_masked[i]) irq_id = IDW'(i);
    end
  end

endmodule

// File: rtl/mio_bus_ctrl.sv
// CPU-side memory/IO controller: decodes accesses to NCH slave channels, stalls the CPU
// until the slave is ready or a timeout raises a bus error, and hosts the interrupt logic.
module mio_bus_ctrl
  import mio_pkg::*;
#(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned NCH      = 4,
  parameter int unsigned CH_SHIFT = 28,
  parameter int unsigned TIMEOUT  = 15,
  parameter int unsigned NINT     = 4,
  localparam int unsigned IDW     = (clog2(NINT) < 1) ? 1 : clog2(NINT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [AW-1:0]     cpu_addr,
  input  logic [DW-1:0]     cpu_wdata,
  output logic [DW-1:0]     cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_err,
  output logic              cpu_stall,
  output logic [NCH-1:0]    ch_sel,
  output logic              ch_we,
  output logic [AW-1:0]     ch_addr,
  output logic [DW-1:0]     ch_wdata,
  input  logic [NCH*DW-1:0] ch_rdata,
  input  logic [NCH-1:0]    ch_ready,
  input  logic [NINT-1:0]   irq_in,
  input  logic [NINT-1:0]   irq_en,
  input  logic [NINT-1:0]   irq_clr,
  output logic [NINT-1:0]   irq_pending,
  output logic [IDW-1:0]    irq_id,
  output logic              cpu_int
);

  localparam int unsigned CIW = (clog2(NCH) < 1) ? 1 : clog2(NCH);
  localparam int unsigned TW  = (clog2(TIMEOUT) < 1) ? 1 : clog2(TIMEOUT);

  state_e          r_state, w_state_next;
  logic            r_we, r_err;
  logic [CIW-1:0]  r_ci;
  logic [TW-1:0]   r_cnt;

  logic [CIW-1:0]  w_ci;
  logic            w_ci_valid, w_ready, w_timeout;
  logic [DW-1:0]   w_rdata_sel;

  assign w_ci        = cpu_addr[CH_SHIFT +: CIW];
  assign w_ci_valid  = 32'(w_ci) < NCH;
  assign w_ready     = ch_ready[r_ci];
  assign w_rdata_sel = ch_rdata[r_ci*DW +: DW];
  assign w_timeout   = (r_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (cpu_req) w_state_next = w_ci_valid ? StAccess : StDone;
      StAccess: if (w_ready || w_timeout) w_state_next = StDone;
      StDone:   w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_comb begin
    cpu_ack   = (r_state == StDone);
    cpu_err   = (r_state == StDone) && r_err;
    cpu_stall = ((r_state == StIdle) && cpu_req) || (r_state == StAccess);
    ch_we     = (r_state == StAccess) && r_we;
    ch_sel    = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      ch_sel[i] = (r_state == StAccess) && (32'(r_ci) == i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we      <= 1'b0;
      r_err     <= 1'b0;
      r_ci      <= '0;
      r_cnt     <= '0;
      ch_addr   <= '0;
      ch_wdata  <= '0;
      cpu_rdata <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (cpu_req) begin
            r_we     <= cpu_we;
            ch_addr  <= cpu_addr;
            ch_wdata <= cpu_wdata;
            r_ci     <= w_ci;
            r_err    <= !w_ci_valid;
            r_cnt    <= '0;
          end
        end
        StAccess: begin
          r_cnt <= r_cnt + 1'b1;
          // Ready beats timeout when both land in the same cycle.
          if (w_ready) begin
            if (!r_we) cpu_rdata <= w_rdata_sel;
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end
        end
        StDone: begin
          r_cnt <= '0;
          r_err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  mio_irq_ctrl #(
    .NINT(NINT)
  ) u_irq (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .irq_en     (irq_en),
    .irq_clr    (irq_clr),
    .irq_pending(irq_pending),
    .irq_id     (irq_id),
    .cpu_int    (cpu_int)
  );

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Directed bench for mio_bus_ctrl: table-driven bus accesses plus hand-written sequences
// for the invalid channel, interrupt and mid-access reset cases.
module tb_mio_bus_ctrl;

  localparam int NEVER = 1000;

  logic         clk;
  logic         reset;
  logic         cpu_req, req3;
  logic         cpu_we;
  logic [31:0]  cpu_addr, cpu_wdata;
  logic [31:0]  cpu_rdata;
  logic         cpu_ack, cpu_err, cpu_stall;
  logic [3:0]   ch_sel;
  logic         ch_we;
  logic [31:0]  ch_addr, ch_wdata;
  logic [127:0] ch_rdata;
  logic [3:0]   ch_ready;
  logic [3:0]   irq_in, irq_en, irq_clr, irq_pending;
  logic [1:0]   irq_id;
  logic         cpu_int;

  // Second instance with three channels for invalid-index decode.
  logic [31:0]  rdata3, chaddr3, chwdata3;
  logic         ack3, err3, stall3, we3, int3;
  logic [2:0]   sel3, ready3;
  logic [95:0]  chrdata3;
  logic [3:0]   irq_zero, pend3;
  logic [1:0]   id3;

  int total = 0;
  int bad   = 0;

  mio_bus_ctrl u_dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
    .cpu_stall(cpu_stall), .ch_sel(ch_sel), .ch_we(ch_we), .ch_addr(ch_addr),
    .ch_wdata(ch_wdata), .ch_rdata(ch_rdata), .ch_ready(ch_ready), .irq_in(irq_in),
    .irq_en(irq_en), .irq_clr(irq_clr), .irq_pending(irq_pending), .irq_id(irq_id),
    .cpu_int(cpu_int)
  );

  mio_bus_ctrl #(.NCH(3)) u_dut3 (
    .clk(clk), .reset(reset), .cpu_req(req3), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(rdata3), .cpu_ack(ack3), .cpu_err(err3),
    .cpu_stall(stall3), .ch_sel(sel3), .ch_we(we3), .ch_addr(chaddr3),
    .ch_wdata(chwdata3), .ch_rdata(chrdata3), .ch_ready(ready3), .irq_in(irq_zero),
    .irq_en(irq_zero), .irq_clr(irq_zero), .irq_pending(pend3), .irq_id(id3),
    .cpu_int(int3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          rdy;        // first cycle ch_ready is high (NEVER = never)
    logic [31:0] rdata;
    int          exp_ack;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_sel;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int         cyc, ack_cyc, ch;
    logic       err;
    logic [31:0] rd;
    logic [3:0] sel1;
    bit         stall_ok, hold_ok;
    string      tag;
    tag      = $sformatf("vec%0d", idx);
    ch       = int'(v.addr[29:28]);
    ack_cyc  = -1;
    err      = 1'bx;
    rd       = 'x;
    sel1     = 'x;
    hold_ok  = 1;
    @(posedge clk); #1;
    cpu_req   = 1'b1;
    cpu_we    = v.we;
    cpu_addr  = v.addr;
    cpu_wdata = v.wdata;
    ch_rdata  = {4{~v.rdata}};
    ch_rdata[ch*32 +: 32] = v.rdata;
    ch_ready  = '0;
    if (v.rdy == 0) ch_ready[ch] = 1'b1;
    #1 stall_ok = (cpu_stall === 1'b1);
    cyc = 0;
    while (cyc < 40 && ack_cyc < 0) begin
      @(posedge clk); #1;
      cyc++;
      cpu_req  = 1'b0;
      ch_ready = '0;
      if (cyc >= v.rdy) ch_ready[ch] = 1'b1;
      if (cyc == 1) begin
        sel1 = ch_sel;
        chk({tag, " ch_addr"}, ch_addr, v.addr);
      end
      if (cpu_ack === 1'b1) begin
        ack_cyc = cyc;
        err     = cpu_err;
        rd      = cpu_rdata;
        if (cpu_stall !== 1'b0) stall_ok = 0;
      end else begin
        if (cpu_stall !== 1'b1) stall_ok = 0;
        if (ch_we !== v.we || ch_wdata !== v.wdata) hold_ok = 0;
      end
    end
    ch_ready = '0;
    chk({tag, " ack_cycle"}, ack_cyc, v.exp_ack);
    chk({tag, " err"}, err, v.exp_err);
    chk({tag, " rdata"}, rd, v.exp_rdata);
    chk({tag, " sel"}, sel1, v.exp_sel);
    chk({tag, " stall"}, stall_ok, 1);
    chk({tag, " we_wdata_hold"}, hold_ok, 1);
  endtask

  vec_t vecs[6];
  bit   saw_ack;

  initial begin
    vecs[0] = '{32'h1000_0004, 1'b0, 32'h0,         0,     32'hCAFE_0001, 2,  1'b0,
                32'hCAFE_0001, 4'b0010};
    vecs[1] = '{32'h0000_0010, 1'b1, 32'h1234_5678, 3,     32'h5555_AAAA, 4,  1'b0,
                32'hCAFE_0001, 4'b0001};
    vecs[2] = '{32'h3000_0008, 1'b0, 32'h0,         5,     32'h0BAD_F00D, 6,  1'b0,
                32'h0BAD_F00D, 4'b1000};
    vecs[3] = '{32'h2000_0000, 1'b0, 32'h0,         NEVER, 32'hDEAD_BEEF, 16, 1'b1,
                32'h0BAD_F00D, 4'b0100};
    // Upper address bits ignored; ready in the timeout cycle still wins.
    vecs[4] = '{32'hE000_0000, 1'b0, 32'h0,         15,    32'h0000_5555, 16, 1'b0,
                32'h0000_5555, 4'b0100};
    vecs[5] = '{32'h0000_0000, 1'b0, 32'h0,         1,     32'hA5A5_A5A5, 2,  1'b0,
                32'hA5A5_A5A5, 4'b0001};

    reset = 1'b0; cpu_req = 1'b0; req3 = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
    cpu_wdata = '0; ch_rdata = '0; ch_ready = '0; irq_in = '0; irq_en = '0;
    irq_clr = '0; irq_zero = '0; ready3 = '0; chrdata3 = '0;
    #1;
    chk("rst ack_err_stall", {cpu_ack, cpu_err, cpu_stall}, 3'b000);
    chk("rst ch_sel_we", {ch_sel, ch_we}, 5'b0);
    chk("rst ch_addr", ch_addr, 32'h0);
    chk("rst rdata", cpu_rdata, 32'h0);
    chk("rst irq", {irq_pending, irq_id, cpu_int}, 7'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Invalid channel on the 3-channel instance.
    @(posedge clk); #1;
    ready3   = 3'b111;
    cpu_addr = 32'h3000_0000;
    cpu_we   = 1'b0;
    req3     = 1'b1;
    #1 chk("inv stall c0", stall3, 1'b1);
    @(posedge clk); #1;
    req3 = 1'b0;
    chk("inv ack_err c1", {ack3, err3}, 2'b11);
    chk("inv sel c1", sel3, 3'b000);
    // Highest valid channel on the same instance completes cleanly.
    @(posedge clk); #1;
    chrdata3 = {32'h7777_0002, 32'h0, 32'h0};
    cpu_addr = 32'h2000_0000;
    req3     = 1'b1;
    @(posedge clk); #1;
    req3 = 1'b0;
    chk("ch2of3 sel c1", sel3, 3'b100);
    @(posedge clk); #1;
    chk("ch2of3 ack c2", {ack3, err3}, 2'b10);
    chk("ch2of3 rdata", rdata3, 32'h7777_0002);
    ready3 = '0;

    // Interrupts.
    irq_en = 4'b1010;
    repeat (2) @(posedge clk);
    #1 irq_in = 4'b1010;
    begin
      int n;
      n = -1;
      for (int k = 1; k <= 10 && n < 0; k++) begin
        @(posedge clk); #1;
        if (irq_pending !== 4'b0000) begin
          n = k;
          chk("irq int before pend+1", cpu_int, 1'b0);
        end
      end
      chk("irq latency", n, 3);
    end
    chk("irq pending", irq_pending, 4'b1010);
    chk("irq id", irq_id, 2'd1);
    @(posedge clk); #1;
    chk("irq cpu_int", cpu_int, 1'b1);
    irq_clr = 4'b0010;
    @(posedge clk); #1;
    irq_clr = 4'b0000;
    chk("irq clr pending", irq_pending, 4'b1000);
    chk("irq clr id", irq_id, 2'd3);
    irq_in[1] = 1'b0;
    repeat (4) @(posedge clk);
    #1 irq_in[1] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    irq_clr = 4'b0010;
    @(posedge clk); #1;
    irq_clr = 4'b0000;
    chk("irq set beats clr", irq_pending, 4'b1010);
    irq_clr = 4'b0010;
    @(posedge clk); #1;
    irq_clr = 4'b0000;
    chk("irq plain clr", irq_pending, 4'b1000);
    irq_en = 4'b0000;
    #1 chk("irq id masked", irq_id, 2'd0);
    @(posedge clk); #1;
    chk("irq int masked", cpu_int, 1'b0);
    irq_en = 4'b1010;

    // Reset in the middle of an access.
    @(posedge clk); #1;
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 32'h1000_0000;
    cpu_wdata = 32'hFEED_0000;
    ch_ready  = '0;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    chk("mid pre sel", {ch_sel, ch_we}, 5'b0010_1);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("mid rst sel_we", {ch_sel, ch_we}, 5'b0);
    chk("mid rst ack_err_stall", {cpu_ack, cpu_err, cpu_stall}, 3'b000);
    chk("mid rst addr_wdata", {ch_addr, ch_wdata}, 64'h0);
    chk("mid rst rdata", cpu_rdata, 32'h0);
    chk("mid rst irq", {irq_pending, cpu_int}, 5'b0);
    ch_ready = 4'b1111;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    saw_ack = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (cpu_ack === 1'b1) saw_ack = 1;
    end
    chk("mid no ack", saw_ack, 1'b0);
    ch_ready = '0;
    run_vec(6, '{32'h1000_0000, 1'b0, 32'h0, 0, 32'h1111_2222, 2, 1'b0,
                 32'h1111_2222, 4'b0010});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
